// File: rtl/seq_alu.sv
// seq_alu: single-stage registered ALU with valid/ready handshake,
// an operand accumulator and a wrapping count of accepted requests.
module seq_alu #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             CLK_in,
  input  logic             RST_N_in,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  logic [1:0]       S_in,
  input  logic             C_in,
  input  logic             ACC_SEL_in,
  input  logic             ACC_CLR_in,
  input  logic             VALID_in,
  output logic             READY_out,
  output logic [WIDTH-1:0] ALU_out,
  output logic             C_out,
  output logic             Z_out,
  output logic             V_out,
  output logic             VALID_out,
  input  logic             READY_in,
  output logic [WIDTH-1:0] ACC_out,
  output logic [CNT_W-1:0] OP_CNT_out
);

  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {
    OP_INV = 2'b00,
    OP_ADD = 2'b01,
    OP_SUB = 2'b10,
    OP_DBL = 2'b11
  } op_t;

  logic             accept;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH:0]   wide;
  logic [WIDTH-1:0] res;
  logic             res_c;
  logic             res_v;

  // A new request can enter whenever the output slot is empty or being drained.
  assign READY_out = !VALID_out || READY_in;
  assign accept    = VALID_in && READY_out;
  assign op_a      = ACC_SEL_in ? ACC_out : A_in;

  // Combinational result and flag generation for the selected opcode.
  always_comb begin
    wide  = '0;
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    unique case (op_t'(S_in))
      OP_INV: begin
        res = ~op_a;
      end
      OP_ADD: begin
        wide  = {1'b0, op_a} + {1'b0, B_in} + {{WIDTH{1'b0}}, C_in};
        res   = wide[MSB:0];
        res_c = wide[WIDTH];
        res_v = (op_a[MSB] == B_in[MSB]) && (res[MSB] != op_a[MSB]);
      end
      OP_SUB: begin
        // Carry out of A + ~B + 1 is the inverted borrow.
        wide  = {1'b0, op_a} + {1'b0, ~B_in} + {{WIDTH{1'b0}}, 1'b1};
        res   = wide[MSB:0];
        res_c = wide[WIDTH];
        res_v = (op_a[MSB] != B_in[MSB]) && (res[MSB] != op_a[MSB]);
      end
      OP_DBL: begin
        res   = {op_a[MSB-1:0], 1'b0};
        res_c = op_a[MSB];
        res_v = op_a[MSB] ^ op_a[MSB-1];
      end
      default: begin
        res = '0;
      end
    endcase
  end

  // Output register: load on accept, otherwise hold; drop valid once drained.
  always_ff @(posedge CLK_in or negedge RST_N_in) begin
    if (!RST_N_in) begin
      ALU_out    <= '0;
      C_out      <= 1'b0;
      Z_out      <= 1'b0;
      V_out      <= 1'b0;
      VALID_out  <= 1'b0;
      OP_CNT_out <= '0;
    end else if (accept) begin
      ALU_out    <= res;
      C_out      <= res_c;
      Z_out      <= (res == '0);
      V_out      <= res_v;
      VALID_out  <= 1'b1;
      OP_CNT_out <= OP_CNT_out + CNT_W'(1);
    end else if (READY_in) begin
      VALID_out  <= 1'b0;
    end
  end

  // Accumulator: clear wins over the accept load; the operand already used the old value.
  always_ff @(posedge CLK_in or negedge RST_N_in) begin
    if (!RST_N_in) begin
      ACC_out <= '0;
    end else if (ACC_CLR_in) begin
      ACC_out <= '0;
    end else if (accept) begin
      ACC_out <= res;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed and randomized checks of seq_alu against an
// arithmetic reference model (WIDTH=4, CNT_W=8).
module tb_seq_alu;

  localparam int W   = 4;
  localparam int CW  = 8;
  localparam int MOD = 1 << W;
  localparam int HALF = 1 << (W - 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  a_in = '0, b_in = '0;
  logic [1:0]    s_in = '0;
  logic          c_in = 1'b0, acc_sel = 1'b0, acc_clr = 1'b0, valid_in = 1'b0, ready_in = 1'b0;
  logic          ready_out, c_out, z_out, v_out, valid_out;
  logic [W-1:0]  alu_out, acc_out;
  logic [CW-1:0] op_cnt;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  int m_valid, m_alu, m_c, m_z, m_v, m_acc, m_cnt;

  seq_alu #(.WIDTH(W), .CNT_W(CW)) dut (
    .CLK_in(clk), .RST_N_in(rst_n), .A_in(a_in), .B_in(b_in), .S_in(s_in),
    .C_in(c_in), .ACC_SEL_in(acc_sel), .ACC_CLR_in(acc_clr), .VALID_in(valid_in),
    .READY_out(ready_out), .ALU_out(alu_out), .C_out(c_out), .Z_out(z_out),
    .V_out(v_out), .VALID_out(valid_out), .READY_in(ready_in), .ACC_out(acc_out),
    .OP_CNT_out(op_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int to_signed(input int x);
    return (x >= HALF) ? x - MOD : x;
  endfunction

  // Opcode semantics in plain integer arithmetic.
  function automatic void ref_op(input int op, input int a, input int b, input int cin,
                                 output int r, output int c, output int z, output int v);
    int s;
    c = 0; v = 0;
    case (op)
      0: r = (MOD - 1) - a;
      1: begin
        s = a + b + cin;
        r = s % MOD; c = (s >= MOD);
        s = to_signed(a) + to_signed(b) + cin;
        v = (s > HALF - 1) || (s < -HALF);
      end
      2: begin
        r = (a - b + MOD) % MOD; c = (a >= b);
        s = to_signed(a) - to_signed(b);
        v = (s > HALF - 1) || (s < -HALF);
      end
      default: begin
        r = (2 * a) % MOD; c = (a >= HALF);
        s = 2 * to_signed(a);
        v = (s > HALF - 1) || (s < -HALF);
      end
    endcase
    z = (r == 0);
  endfunction

  task automatic model_reset();
    m_valid = 0; m_alu = 0; m_c = 0; m_z = 0; m_v = 0; m_acc = 0; m_cnt = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".alu"},   int'(alu_out),   m_alu);
    check({tag, ".c"},     int'(c_out),     m_c);
    check({tag, ".z"},     int'(z_out),     m_z);
    check({tag, ".v"},     int'(v_out),     m_v);
    check({tag, ".valid"}, int'(valid_out), m_valid);
    check({tag, ".acc"},   int'(acc_out),   m_acc);
    check({tag, ".cnt"},   int'(op_cnt),    m_cnt);
  endtask

  // One clock: check ready before the edge, advance model at the edge, check after.
  task automatic cycle(input string tag);
    int acc_ok, r, c, z, v, opa;
    #1;
    acc_ok = valid_in && (!m_valid || ready_in);
    check({tag, ".ready"}, int'(ready_out), (!m_valid || ready_in) ? 1 : 0);
    @(posedge clk);
    opa = acc_sel ? m_acc : int'(a_in);
    ref_op(int'(s_in), opa, int'(b_in), int'(c_in), r, c, z, v);
    if (acc_ok) begin
      m_alu = r; m_c = c; m_z = z; m_v = v; m_valid = 1;
      m_cnt = (m_cnt + 1) % (1 << CW);
    end else if (ready_in) begin
      m_valid = 0;
    end
    if (acc_clr) m_acc = 0;
    else if (acc_ok) m_acc = r;
    #1;
    check_outputs(tag);
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input int a, input int b,
                       input logic ci, input logic sel, input logic clr, input logic rdy);
    valid_in = v; s_in = s; a_in = W'(a); b_in = W'(b);
    c_in = ci; acc_sel = sel; acc_clr = clr; ready_in = rdy;
  endtask

  initial begin
    model_reset();
    #2;
    check_outputs("rst");
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    // Backpressure holds the result and blocks new requests.
    drive(1, 2'b01, 2, 10, 0, 0, 0, 1); cycle("bp_acc");
    check("bp.alu12", int'(alu_out), 12);
    for (int i = 0; i < 3; i++) begin
      drive(1, 2'b01, 1, 1, 0, 0, 0, 0); cycle("bp_hold");
      check("bp.hold_alu", int'(alu_out), 12);
      check("bp.hold_ready", int'(ready_out), 0);
      check("bp.hold_cnt", int'(op_cnt), 1);
    end
    drive(1, 2'b01, 1, 1, 0, 0, 0, 1);
    #1 check("bp.release_ready", int'(ready_out), 1);
    cycle("bp_release");
    check("bp.release_alu", int'(alu_out), 2);
    check("bp.release_cnt", int'(op_cnt), 2);

    // Per-opcode corner values.
    drive(1, 2'b00, 15, 0, 0, 0, 0, 1); cycle("inv");
    check("inv.alu", int'(alu_out), 0); check("inv.z", int'(z_out), 1);
    drive(1, 2'b01, 3, 5, 0, 0, 0, 1); cycle("add");
    check("add.alu", int'(alu_out), 8); check("add.c", int'(c_out), 0); check("add.v", int'(v_out), 1);
    drive(1, 2'b10, 2, 5, 1, 0, 0, 1); cycle("sub1");
    check("sub1.alu", int'(alu_out), 13); check("sub1.c", int'(c_out), 0); check("sub1.v", int'(v_out), 0);
    drive(1, 2'b10, 13, 2, 0, 0, 0, 1); cycle("sub2");
    check("sub2.alu", int'(alu_out), 11); check("sub2.c", int'(c_out), 1);
    drive(1, 2'b11, 7, 0, 0, 0, 0, 1); cycle("dbl");
    check("dbl.alu", int'(alu_out), 14); check("dbl.c", int'(c_out), 0); check("dbl.v", int'(v_out), 1);

    // Accumulator chain.
    drive(0, 2'b00, 0, 0, 0, 0, 1, 1); cycle("acc_clr");
    check("acc_clr.acc", int'(acc_out), 0);
    for (int i = 1; i <= 3; i++) begin
      drive(1, 2'b01, 0, 3, 0, 1, 0, 1); cycle("acc_add");
      check("acc_add.acc", int'(acc_out), 3 * i);
    end
    drive(1, 2'b11, 0, 0, 0, 1, 0, 1); cycle("acc_dbl");
    check("acc_dbl.alu", int'(alu_out), 2); check("acc_dbl.c", int'(c_out), 1); check("acc_dbl.v", int'(v_out), 1);

    // Clear together with an accumulator-operand accept.
    drive(0, 2'b00, 0, 0, 0, 0, 1, 1); cycle("cc_clr");
    drive(1, 2'b01, 0, 9, 0, 1, 0, 1); cycle("cc_load9");
    check("cc_load9.acc", int'(acc_out), 9);
    drive(1, 2'b01, 0, 1, 0, 1, 1, 1); cycle("cc_both");
    check("cc_both.alu", int'(alu_out), 10); check("cc_both.acc", int'(acc_out), 0);

    // Randomized traffic with backpressure and idle cycles.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom_range(0, MOD - 1),
            $urandom_range(0, MOD - 1), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7);
      cycle("rnd");
    end

    // Reset while a result is stalled.
    drive(1, 2'b01, 4, 4, 0, 0, 0, 1); cycle("rst_setup");
    drive(1, 2'b01, 1, 1, 0, 0, 0, 0); cycle("rst_stall");
    check("rst_stall.valid", int'(valid_out), 1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("rst_async");
    @(negedge clk);
    rst_n = 1'b1;

    // First post-release request, then back-to-back to a full counter wrap.
    drive(1, 2'b10, 9, 3, 0, 0, 0, 1); cycle("post_rst");
    check("post_rst.alu", int'(alu_out), 6); check("post_rst.c", int'(c_out), 1);
    for (int i = 1; i < 256; i++) begin
      drive(1, 2'($urandom_range(0, 3)), $urandom_range(0, MOD - 1), $urandom_range(0, MOD - 1),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 1);
      cycle("b2b");
      check("b2b.valid", int'(valid_out), 1);
    end
    check("b2b.wrap", int'(op_cnt), 0);

    drive(0, 2'b00, 0, 0, 0, 0, 0, 1); cycle("drain");
    check("drain.valid", int'(valid_out), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
